// File: rtl/aes_key_expand.sv
// AES-128 key schedule: presents round keys 0..10 on rkey/addr, one per clock, after a start request.
// Optional abort input is compiled in when KEY_EXPAND_ABORT_EN is defined.
module aes_key_expand #(
   parameter logic [3:0] IDLE_ADDR = 4'hF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
`ifdef KEY_EXPAND_ABORT_EN
   input  logic         abort,
`endif
   output logic [127:0] rkey,
   output logic [3:0]   addr,
   output logic         busy,
   output logic         done
);

   typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

   state_t       state_r;
   logic [3:0]   round_r;
   logic [127:0] next_rkey_s;
   logic         abort_s;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         acc = acc ^ (sh & {8{b[i]}});
         sh  = {sh[6:0], 1'b0} ^ (8'h1b & {8{sh[7]}});
      end
      return acc;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] p;
      sq = gf_mul(x, x);
      p  = sq;
      for (int k = 2; k < 8; k++) begin
         sq = gf_mul(sq, sq);
         p  = gf_mul(p, sq);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      logic [7:0] r;
      case (n)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

`ifdef KEY_EXPAND_ABORT_EN
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   // Next round key derived from the currently presented one
   always_comb begin
      logic [31:0] w0_s, w1_s, w2_s, w3_s;
      w0_s = rkey[127:96] ^ sub_word({rkey[23:0], rkey[31:24]}) ^ {rcon(round_r + 4'd1), 24'h000000};
      w1_s = rkey[95:64] ^ w0_s;
      w2_s = rkey[63:32] ^ w1_s;
      w3_s = rkey[31:0]  ^ w2_s;
      next_rkey_s = {w0_s, w1_s, w2_s, w3_s};
   end

   // Sequencer: capture key on start, then step one round per clock up to round 10
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         round_r <= 4'd0;
         rkey    <= 128'h0;
         addr    <= IDLE_ADDR;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r <= EXPAND;
                  round_r <= 4'd0;
                  rkey    <= key;
                  addr    <= 4'd0;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end else begin
                  addr    <= IDLE_ADDR;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end
            end
            EXPAND: begin
               if (abort_s || (round_r == 4'd10)) begin
                  state_r <= IDLE;
                  round_r <= 4'd0;
                  addr    <= IDLE_ADDR;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end else begin
                  round_r <= round_r + 4'd1;
                  addr    <= round_r + 4'd1;
                  rkey    <= next_rkey_s;
                  done    <= (round_r == 4'd9);
               end
            end
            default: begin
               state_r <= IDLE;
               round_r <= 4'd0;
               addr    <= IDLE_ADDR;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 word-level reference model with a table S-box.
module tb_aes_key_expand;

   logic         clk;
   logic         rst;
   logic         start;
   logic [127:0] key;
   logic [127:0] rkey;
   logic [3:0]   addr;
   logic         busy;
   logic         done;
`ifdef KEY_EXPAND_ABORT_EN
   logic         abort;
`endif

   int checks = 0;
   int errors = 0;

   logic [127:0] ref_rk [0:10];
   logic [127:0] obs_rk [0:10];

   logic [7:0] sbox_tab [0:255] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

   aes_key_expand dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .key   (key),
`ifdef KEY_EXPAND_ABORT_EN
      .abort (abort),
`endif
      .rkey  (rkey),
      .addr  (addr),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sub_word_ref(input logic [31:0] x);
      return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
   endfunction

   // FIPS-197 KeyExpansion over the flat word array w[0..43]
   function automatic void build_ref(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = sub_word_ref({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   task automatic check_idle(input string tag, input logic [127:0] exp_rkey);
      check_val({tag, "_addr"}, 128'(addr), 128'(4'hF));
      check_val({tag, "_busy"}, 128'(busy), 128'(1'b0));
      check_val({tag, "_done"}, 128'(done), 128'(1'b0));
      check_val({tag, "_rkey"}, rkey, exp_rkey);
   endtask

   task automatic check_round(input int n);
      check_val($sformatf("addr%0d", n), 128'(addr), 128'(n));
      check_val($sformatf("rkey%0d", n), rkey, ref_rk[n]);
      check_val($sformatf("busy%0d", n), 128'(busy), 128'(1'b1));
      check_val($sformatf("done%0d", n), 128'(done), 128'(n == 10));
      obs_rk[n] = rkey;
   endtask

   // One full run from a negedge; optionally re-pulses start and changes key at round 5
   task automatic run_seq(input logic [127:0] k, input bit disturb);
      build_ref(k);
      start = 1'b1;
      key   = k;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n <= 10; n++) begin
         check_round(n);
         if (disturb && n == 5) begin
            start = 1'b1;
            key   = {$urandom, $urandom, $urandom, $urandom};
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      check_idle("end", ref_rk[10]);
   endtask

   initial begin
      logic [127:0] k;
      int done_cnt;
      int p;
      rst   = 1'b0;
      start = 1'b0;
      key   = 128'h0;
`ifdef KEY_EXPAND_ABORT_EN
      abort = 1'b0;
`endif
      @(negedge clk);
      check_idle("reset", 128'h0);
      rst = 1'b1;
      @(negedge clk);
      check_idle("post_reset", 128'h0);

      // FIPS-197 known-answer key
      run_seq(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
      check_val("kat_r0", obs_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
      check_val("kat_r1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
      check_val("kat_r10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      run_seq(128'h0, 1'b0);
      check_val("zero_r1", obs_rk[1], 128'h62636363626363636263636362636363);
      check_val("zero_r10", obs_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // start and key wiggled mid-run must not disturb the sequence
      run_seq(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
      check_val("dist_r10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      @(negedge clk);
      check_idle("dist_stay", ref_rk[10]);

      for (int i = 0; i < 4; i++) run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b0);

      // asynchronous reset in the middle of round 6
      k = {$urandom, $urandom, $urandom, $urandom};
      build_ref(k);
      start = 1'b1;
      key   = k;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n <= 6; n++) begin
         check_round(n);
         if (n < 6) @(negedge clk);
      end
      #2 rst = 1'b0;
      #1 check_idle("async_rst", 128'h0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_idle("rst_quiet", 128'h0);
      end

      // start held for 30 cycles: runs back to back with one idle cycle between
      k = {$urandom, $urandom, $urandom, $urandom};
      build_ref(k);
      start    = 1'b1;
      key      = k;
      done_cnt = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         p = (c - 1) % 12;
         if (c <= 24 && done) done_cnt++;
         if (p < 11) begin
            check_val($sformatf("hold_addr_c%0d", c), 128'(addr), 128'(p));
            check_val($sformatf("hold_rkey_c%0d", c), rkey, ref_rk[p]);
         end else begin
            check_idle($sformatf("hold_gap_c%0d", c), ref_rk[10]);
         end
      end
      start = 1'b0;
      check_val("hold_done_cnt", 128'(done_cnt), 128'(2));
      repeat (12) @(negedge clk);
      check_idle("hold_drain", ref_rk[10]);

`ifdef KEY_EXPAND_ABORT_EN
      k = {$urandom, $urandom, $urandom, $urandom};
      build_ref(k);
      start = 1'b1;
      key   = k;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n <= 3; n++) begin
         check_round(n);
         if (n < 3) @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle("abort", ref_rk[3]);
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || addr != 4'hF) done_cnt++;
      end
      check_val("abort_quiet", 128'(done_cnt), 128'(0));
      run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
